// File: rtl/dbus_rr_xfer.sv
// dbus_rr_xfer: round-robin arbitrated, registered data-bus transfer engine.
// Define DBUS_CONTENTION_CNT_EN to add the saturating contention_cnt output.

module dbus_dst_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic mask,
  input  logic valid,
  input  logic rdy,
  output logic pend,
  output logic ld
);
  assign ld = valid & pend & rdy;

  // load only fires on an IDLE grant edge, where valid (and so ld) is low
  always_ff @(posedge clk) begin
    if (!rst_n)    pend <= 1'b0;
    else if (load) pend <= mask;
    else if (ld)   pend <= 1'b0;
  end
endmodule

module dbus_rr_xfer #(
  parameter  int WIDTH = 8,
  parameter  int NSRC  = 6,
  parameter  int NDST  = 4,
  localparam int SW    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      src_req,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC*NDST-1:0] src_dst,
  input  logic [NDST-1:0]      dst_rdy,
  output logic [NSRC-1:0]      src_gnt,
  output logic [WIDTH-1:0]     bus_data,
  output logic                 bus_valid,
  output logic [SW-1:0]        bus_src,
  output logic [NDST-1:0]      dst_ld,
  output logic                 busy_err
`ifdef DBUS_CONTENTION_CNT_EN
  ,
  output logic [15:0]          contention_cnt
`endif
);
  typedef enum logic {IDLE, XFER} state_t;

  state_t                      state, state_nxt;
  logic [NSRC-1:0][WIDTH-1:0]  src_word;
  logic [NSRC-1:0][NDST-1:0]   src_mask;
  logic [SW-1:0]               ptr, ptr_nxt, win, hi_idx, lo_idx;
  logic                        hi_hit, lo_hit, any_req, grant;
  logic [NDST-1:0]             pend, mask_sel;
  logic [WIDTH-1:0]            data_nxt;
  logic [SW-1:0]               src_nxt;
  logic [NSRC-1:0]             gnt_nxt;
  logic                        valid_nxt, err_nxt;

  assign src_word = src_data;
  assign src_mask = src_dst;
  assign any_req  = |src_req;

  // Round robin: lowest requester above ptr wins, else lowest at/below ptr (wrap).
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NSRC-1; j >= 0; j--) begin
      if (src_req[j]) begin
        if (SW'(j) > ptr) begin
          hi_hit = 1'b1;
          hi_idx = SW'(j);
        end else begin
          lo_hit = 1'b1;
          lo_idx = SW'(j);
        end
      end
    end
    win = hi_hit ? hi_idx : lo_idx;
  end

  assign mask_sel = src_mask[win];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    data_nxt  = bus_data;
    src_nxt   = bus_src;
    valid_nxt = bus_valid;
    err_nxt   = busy_err;
    gnt_nxt   = '0;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant        = 1'b1;
          state_nxt    = XFER;
          ptr_nxt      = win;
          src_nxt      = win;
          data_nxt     = src_word[win];
          valid_nxt    = 1'b1;
          gnt_nxt[win] = 1'b1;
        end
      end
      XFER: begin
        // Done once every still-pending destination loads this cycle.
        if ((pend & ~dst_ld) == '0) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          if (pend == '0) err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= SW'(NSRC-1);
      bus_data  <= '0;
      bus_src   <= '0;
      bus_valid <= 1'b0;
      src_gnt   <= '0;
      busy_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      bus_data  <= data_nxt;
      bus_src   <= src_nxt;
      bus_valid <= valid_nxt;
      src_gnt   <= gnt_nxt;
      busy_err  <= err_nxt;
    end
  end

  dbus_dst_lane u_lane [NDST-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant),
    .mask  (mask_sel),
    .valid (bus_valid),
    .rdy   (dst_rdy),
    .pend  (pend),
    .ld    (dst_ld)
  );

`ifdef DBUS_CONTENTION_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      contention_cnt <= '0;
    else if (grant && ($countones(src_req) >= 2) && (contention_cnt != 16'hFFFF))
      contention_cnt <= contention_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dbus_rr_xfer.sv
// Scoreboard bench for dbus_rr_xfer: a transfer-level model predicts each cycle's
// bus outputs; a negedge monitor pops and compares them against the DUT.
module tb_dbus_rr_xfer;
  localparam int WIDTH = 8;
  localparam int NSRC  = 6;
  localparam int NDST  = 4;
  localparam int SW    = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NSRC-1:0]        src_req = '0;
  logic [NSRC*WIDTH-1:0]  src_data = '0;
  logic [NSRC*NDST-1:0]   src_dst = '0;
  logic [NDST-1:0]        dst_rdy = '0;
  logic [NSRC-1:0]        src_gnt;
  logic [WIDTH-1:0]       bus_data;
  logic                   bus_valid;
  logic [SW-1:0]          bus_src;
  logic [NDST-1:0]        dst_ld;
  logic                   busy_err;
  logic [15:0]            cnt_dut;

`ifdef DBUS_CONTENTION_CNT_EN
  logic [15:0] contention_cnt;
  assign cnt_dut = contention_cnt;
`else
  assign cnt_dut = 16'd0;
`endif

  dbus_rr_xfer #(.WIDTH(WIDTH), .NSRC(NSRC), .NDST(NDST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_req   (src_req),
    .src_data  (src_data),
    .src_dst   (src_dst),
    .dst_rdy   (dst_rdy),
    .src_gnt   (src_gnt),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_src   (bus_src),
    .dst_ld    (dst_ld),
    .busy_err  (busy_err)
`ifdef DBUS_CONTENTION_CNT_EN
    ,
    .contention_cnt (contention_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int gnt; int valid; int src; int data; int ld; int err; int cnt;
  } exp_t;
  exp_t q[$];

  int  nchk = 0;
  int  npass = 0;
  bit  mon_en = 1'b0;

  // transfer-level reference model
  int   m_valid, m_src, m_data, m_pend, m_ptr, m_gnt, m_err, m_cnt;
  logic [NSRC-1:0]  s_req = '0;
  logic [WIDTH-1:0] s_data [NSRC];
  logic [NDST-1:0]  s_mask [NSRC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        nchk++;
        $display("FAIL scoreboard_underflow: got no expectation at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("src_gnt",   32'(src_gnt),   e.gnt);
        chk("bus_valid", 32'(bus_valid), e.valid);
        chk("bus_src",   32'(bus_src),   e.src);
        chk("bus_data",  32'(bus_data),  e.data);
        chk("dst_ld",    32'(dst_ld),    e.ld);
        chk("busy_err",  32'(busy_err),  e.err);
`ifdef DBUS_CONTENTION_CNT_EN
        chk("contention_cnt", 32'(cnt_dut), e.cnt);
`endif
      end
    end
  end

  function automatic void model_reset();
    m_valid = 0; m_src = 0; m_data = 0; m_pend = 0;
    m_ptr = NSRC-1; m_gnt = 0; m_err = 0; m_cnt = 0;
  endfunction

  // One cycle: called 1ns after a rising edge; drives inputs, records the
  // expected view of this cycle, then advances the model across the next edge.
  task automatic step(input bit rst, input logic [NSRC-1:0] raise, input logic [NDST-1:0] rdy);
    int ld, win;
    exp_t e;
    s_req = s_req & ~NSRC'(m_gnt);   // granted source drops its request
    s_req = s_req | raise;
    src_req = s_req;
    for (int i = 0; i < NSRC; i++) begin
      src_data[i*WIDTH +: WIDTH] = s_data[i];
      src_dst[i*NDST +: NDST]    = s_mask[i];
    end
    dst_rdy = rdy;
    rst_n   = !rst;
    ld = m_valid ? (m_pend & int'(rdy)) : 0;
    e.gnt = m_gnt; e.valid = m_valid; e.src = m_src; e.data = m_data;
    e.ld = ld; e.err = m_err; e.cnt = m_cnt;
    q.push_back(e);
    if (rst) model_reset();
    else if (!m_valid) begin
      m_gnt = 0;
      if (s_req != 0) begin
        win = -1;
        for (int k = 1; k <= NSRC; k++)
          if (win < 0 && s_req[(m_ptr + k) % NSRC]) win = (m_ptr + k) % NSRC;
        if ($countones(s_req) >= 2 && m_cnt < 65535) m_cnt++;
        m_valid = 1; m_src = win; m_ptr = win; m_gnt = 1 << win;
        m_data = int'(s_data[win]); m_pend = int'(s_mask[win]);
      end
    end else begin
      m_gnt = 0;
      if ((m_pend & ~ld) == 0) begin
        m_valid = 0;
        if (m_pend == 0) m_err = 1;
      end
      m_pend = m_pend & ~ld;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic [NDST-1:0] rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  initial begin
    for (int i = 0; i < NSRC; i++) begin s_data[i] = '0; s_mask[i] = '0; end
    @(posedge clk); #1;
    model_reset();
    mon_en = 1'b1;
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);

    // single DR transfer to A
    s_data[0] = 8'd12; s_mask[0] = 4'b0001;
    step(1'b0, 6'b000001, 4'hF);
    idle(3, 4'hF);

    // R0 to B then IR, destinations ready in different cycles
    s_data[1] = 8'd23; s_mask[1] = 4'b0110;
    step(1'b0, 6'b000010, 4'b0010);
    step(1'b0, '0, 4'b0010);
    step(1'b0, '0, 4'b0010);
    step(1'b0, '0, 4'b0100);
    idle(3, 4'b0100);

    // DR and R0 contend continuously
    s_data[0] = 8'd123; s_mask[0] = 4'b0001;
    s_data[1] = 8'd231; s_mask[1] = 4'b0010;
    for (int i = 0; i < 6; i++) step(1'b0, 6'b000011, 4'hF);
    idle(5, 4'hF);

    // ALU granted, then ALU and DR: pointer wraps to DR
    s_data[5] = 8'd55; s_mask[5] = 4'b1000;
    step(1'b0, 6'b100000, 4'hF);
    s_data[0] = 8'd77;
    step(1'b0, 6'b100001, 4'hF);
    idle(6, 4'hF);

    // R3 with an empty destination mask
    s_data[4] = 8'd99; s_mask[4] = 4'b0000;
    step(1'b0, 6'b010000, 4'hF);
    idle(4, 4'hF);

    // reset during a stalled transfer, then everyone requests
    s_data[2] = 8'd44; s_mask[2] = 4'b1100;
    step(1'b0, 6'b000100, 4'h0);
    idle(3, 4'h0);
    step(1'b1, '0, 4'h0);
    for (int i = 0; i < NSRC; i++) begin s_data[i] = 8'(8'h10 + i); s_mask[i] = 4'(i + 1); end
    step(1'b0, 6'h3F, 4'hF);
    idle(16, 4'hF);

    // random traffic
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NSRC; i++)
        if (!s_req[i]) begin
          s_data[i] = 8'($urandom);
          s_mask[i] = 4'($urandom_range(0, 15));
        end
      step($urandom_range(0, 99) == 0, NSRC'($urandom & $urandom), 4'($urandom));
    end
    idle(24, 4'hF);

    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
